// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester link controller.
// Build option: MANCH_PARITY_EN adds the PARITY state.
package manchester_pkg;

`ifdef MANCH_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DATA, PARITY, GAP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DATA, GAP
  } state_t;
`endif

  // Preamble bits are read MSB first: 1,0,1,0,...
  localparam logic [15:0] PREAMBLE_PAT = 16'hAAAA;
  localparam logic IDLE_LEVEL = 1'b0;

  function automatic logic preamble_bit(
    input logic [3:0] idx
  );
    return PREAMBLE_PAT[4'd15 - idx];
  endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Half-bit timer: strobes on the last cycle of each half and
// tracks which half of the bit is on the line.
module manchester_bit_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_end,
  output logic second_half
);

  logic [7:0] cnt;

  assign half_end = (cnt == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt         <= '0;
      second_half <= 1'b0;
    end else if (half_end) begin
      cnt         <= '0;
      second_half <= ~second_half;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/manchester_link_ctrl.sv
// Two-requester round-robin Manchester transmitter.
// Build option: MANCH_PARITY_EN appends an even-parity bit.
module manchester_link_ctrl
  import manchester_pkg::*;
#(
  parameter int HALF_PERIOD  = 4,
  parameter int PREAMBLE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       tx_line,
  output logic       tx_active,
  output logic       grant_id,
  output logic       frame_done
);

  localparam logic [3:0] LAST_PRE = 4'(PREAMBLE_LEN - 1);

  state_t     state, state_nxt;
  logic [3:0] bit_cnt;
  logic [7:0] data_q;
  logic       last_grant;
  logic       grant;
  logic       pick;
  logic       tx_bit;
  logic       half_end;
  logic       second_half;
  logic       bit_end;

  manchester_bit_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .restart    (grant),
    .half_end   (half_end),
    .second_half(second_half)
  );

  assign bit_end = half_end & second_half;

  // On a tie the requester not served last wins.
  assign pick = (req0_valid && req1_valid) ? ~last_grant
                                           : req1_valid;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          req0_ready = ~pick;
          req1_ready = pick;
          state_nxt  = (PREAMBLE_LEN == 0) ? DATA : PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (bit_end && bit_cnt == LAST_PRE)
          state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == 4'd7)
`ifdef MANCH_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = GAP;
`endif
      end
`ifdef MANCH_PARITY_EN
      PARITY: begin
        if (bit_end)
          state_nxt = GAP;
      end
`endif
      GAP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      data_q     <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant || (bit_end && state_nxt != state))
        bit_cnt <= '0;
      else if (bit_end)
        bit_cnt <= bit_cnt + 4'd1;
      if (grant) begin
        data_q     <= pick ? req1_data : req0_data;
        grant_id   <= pick;
        last_grant <= pick;
      end
    end
  end

  always_comb begin
    tx_bit = 1'b0;
    unique case (state)
      PREAMBLE: tx_bit = preamble_bit(bit_cnt);
      DATA:     tx_bit = data_q[~bit_cnt[2:0]];
`ifdef MANCH_PARITY_EN
      PARITY:   tx_bit = ^data_q;
`endif
      default:  tx_bit = 1'b0;
    endcase
  end

  assign tx_active = (state != IDLE) && (state != GAP);
  // Bit 1 is low-then-high, bit 0 high-then-low.
  assign tx_line   = tx_active ? (second_half ? tx_bit : ~tx_bit)
                               : IDLE_LEVEL;

endmodule

// File: tb/tb_manchester_link_ctrl.sv
// Directed bench for manchester_link_ctrl: framing, arbitration,
// reset abort, and a HALF_PERIOD=1 / no-preamble instance.
module tb_manchester_link_ctrl;
  import manchester_pkg::*;

  localparam int HP = 2;
  localparam int PL = 4;
`ifdef MANCH_PARITY_EN
  localparam int NB = PL + 9;
`else
  localparam int NB = PL + 8;
`endif
  localparam int FLEN = NB * 2 * HP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       tx_line, tx_active, grant_id, frame_done;

  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [7:0] b_req0_data = '0, b_req1_data = '0;
  logic       b_req0_ready, b_req1_ready;
  logic       b_tx_line, b_tx_active, b_grant_id, b_frame_done;

  always #5 clk = ~clk;

  manchester_link_ctrl #(.HALF_PERIOD(HP), .PREAMBLE_LEN(PL)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .tx_line(tx_line), .tx_active(tx_active),
    .grant_id(grant_id), .frame_done(frame_done)
  );

  manchester_link_ctrl #(.HALF_PERIOD(1), .PREAMBLE_LEN(0)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
    .req0_data(b_req0_data), .req1_data(b_req1_data),
    .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
    .tx_line(b_tx_line), .tx_active(b_tx_active),
    .grant_id(b_grant_id), .frame_done(b_frame_done)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    int         len;
    logic [7:0] data;
    logic       pre_ok;
    logic       enc_ok;
    logic       par;
    logic       gid;
    int         gap;
  } frame_t;

  frame_t frames[$];
  int     grants[$];
  logic   lvl[0:255];
  int     cur_len = 0;
  int     gap = 0;
  bit     pend = 0;
  int     done_cnt = 0;
  int     r0_cnt = 0;
  int     bad_idle = 0;
  int     bad_rdy = 0;
  frame_t cur;

  always @(negedge clk) begin
    if (rst) begin
      cur_len = 0;
      pend    = 0;
    end else begin
      if (req0_valid && req0_ready) grants.push_back(0);
      if (req1_valid && req1_ready) grants.push_back(1);
      if (req0_ready) r0_cnt++;
      if ((req0_ready || req1_ready) && tx_active) bad_rdy++;
      if (!tx_active && tx_line) bad_idle++;
      if (tx_active) begin
        if (cur_len < 256) lvl[cur_len] = tx_line;
        cur_len++;
        cur.gid = grant_id;
      end else if (cur_len > 0) begin
        logic [15:0] bits;
        bits       = '0;
        cur.len    = cur_len;
        cur.enc_ok = (cur_len == FLEN);
        cur.pre_ok = 1'b1;
        cur.data   = '0;
        cur.par    = 1'b0;
        if (cur.enc_ok) begin
          for (int b = 0; b < NB; b++) begin
            for (int h = 0; h < HP; h++) begin
              if (lvl[b*2*HP+h] !== lvl[b*2*HP]) cur.enc_ok = 0;
              if (lvl[b*2*HP+HP+h] !== lvl[b*2*HP+HP]) cur.enc_ok = 0;
            end
            if (lvl[b*2*HP] === lvl[b*2*HP+HP]) cur.enc_ok = 0;
            bits[b] = lvl[b*2*HP+HP];
          end
          for (int i = 0; i < PL; i++)
            if (bits[i] !== ((i % 2) == 0)) cur.pre_ok = 0;
          for (int i = 0; i < 8; i++) cur.data[7-i] = bits[PL+i];
          cur.par = bits[PL+8];
        end
        pend    = 1;
        gap     = 1;
        cur_len = 0;
      end else if (pend) begin
        gap++;
      end
      if (frame_done) begin
        done_cnt++;
        if (pend) begin
          cur.gap = gap;
          frames.push_back(cur);
          pend = 0;
        end
      end
    end
  end

  task automatic cycle_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle_drive();
    rst = 1'b1;
    cycle_drive();
    cycle_drive();
    rst = 1'b0;
    frames.delete();
    grants.delete();
    r0_cnt = 0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("frames_seen", frames.size(), n);
  endtask

  task automatic check_frame(input string tag, input int idx,
                             input logic [7:0] d, input logic g);
    if (idx >= frames.size()) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      check({tag, "_len"}, frames[idx].len, FLEN);
      check({tag, "_data"}, frames[idx].data, d);
      check({tag, "_pre"}, frames[idx].pre_ok, 1);
      check({tag, "_enc"}, frames[idx].enc_ok, 1);
      check({tag, "_gid"}, frames[idx].gid, g);
      check({tag, "_gap"}, frames[idx].gap, 2 * HP);
`ifdef MANCH_PARITY_EN
      check({tag, "_par"}, frames[idx].par, ^d);
`endif
    end
  endtask

  initial begin
    int k;
    int dc;
    logic b_lvl[0:63];
    int   b_len;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", tx_line, 0);
    check("rst_active", tx_active, 0);
    check("rst_gid", grant_id, 0);
    check("rst_done", frame_done, 0);
    check("rst_rdy", {req0_ready, req1_ready}, 0);
    check("rst_state", u_dut.state == IDLE, 1);
    do_reset();

    // single byte 0xA5, data changed after acceptance
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    #1;
    check("a5_rdy0", req0_ready, 1);
    check("a5_rdy1", req1_ready, 0);
    cycle_drive();
    check("a5_rdy_drop", req0_ready, 0);
    req0_valid = 1'b0;
    req0_data  = 8'hFF;
    wait_frames(1);
    check_frame("a5", 0, 8'hA5, 0);
    check("a5_rdy_cycles", r0_cnt, 1);

    // 0x07: parity bit is 1 when enabled
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h07;
    cycle_drive();
    req0_valid = 1'b0;
    wait_frames(1);
    check_frame("x07", 0, 8'h07, 0);

    // tie from reset: req0 first, then req1
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h11;
    req1_valid = 1'b1;
    req1_data  = 8'h22;
    #1;
    check("tie_rdy0", req0_ready, 1);
    check("tie_rdy1", req1_ready, 0);
    cycle_drive();
    req0_valid = 1'b0;
    k = 0;
    while (grants.size() < 2 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    cycle_drive();
    req1_valid = 1'b0;
    wait_frames(2);
    check_frame("tie0", 0, 8'h11, 0);
    check_frame("tie1", 1, 8'h22, 1);

    // fairness: both held for 4 frames
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    req1_valid = 1'b1;
    req1_data  = 8'hC3;
    k = 0;
    while (grants.size() < 4 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    cycle_drive();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_frames(4);
    check("fair_ngrants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("fair_grant", grants[i], i % 2);
    check_frame("fair0", 0, 8'h3C, 0);
    check_frame("fair1", 1, 8'hC3, 1);
    check_frame("fair2", 2, 8'h3C, 0);
    check_frame("fair3", 3, 8'hC3, 1);

    // reset in DATA bit 3 aborts the frame
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h5A;
    cycle_drive();
    req0_valid = 1'b0;
    k = 0;
    while (cur_len < PL*2*HP + 3*2*HP + 1 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_reached", cur_len >= PL*2*HP + 3*2*HP + 1, 1);
    dc  = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_line", tx_line, 0);
    check("abort_active", tx_active, 0);
    check("abort_state", u_dut.state == IDLE, 1);
    check("abort_done", frame_done, 0);
    rst = 1'b0;
    repeat (4 * FLEN) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_no_frame", frames.size(), 0);

    // HALF_PERIOD=1, no preamble, 0x80
    cycle_drive();
    b_req0_valid = 1'b1;
    b_req0_data  = 8'h80;
    cycle_drive();
    b_req0_valid = 1'b0;
    b_len = 0;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (b_tx_active) begin
        if (b_len < 64) b_lvl[b_len] = b_tx_line;
        b_len++;
      end else if (b_len > 0) begin
        break;
      end
    end
    check("b_len", b_len, 16);
    check("b_h0", b_lvl[0], 0);
    check("b_h1", b_lvl[1], 1);
    check("b_h2", b_lvl[2], 1);
    check("b_h3", b_lvl[3], 0);
    check("b_h15", b_lvl[15], 0);

    check("idle_line_low", bad_idle, 0);
    check("ready_only_idle", bad_rdy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
